// File: rtl/sprite_pixel_renderer.sv
// Purpose: per-pixel sprite lookup; drives Pac-Man/ghost ROM row addresses and emits texel-on flags.
// Latency: 2 cycles from DrawX/DrawY to pac_on/ghost_on, one pixel accepted every cycle.
// Backpressure: none; the pipeline never stalls and follows the scan counters unconditionally.
module sprite_pixel_renderer #(
    parameter int SCALE_SHIFT = 1,
    parameter int ANIM_FRAMES = 8
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_start,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    input  logic [9:0] pac_x,
    input  logic [9:0] pac_y,
    input  logic [1:0] pac_dir,
    input  logic       pac_moving,
    input  logic [9:0] ghost_x,
    input  logic [9:0] ghost_y,
    output logic [2:0] pac_addr,
    output logic [2:0] ghost_addr,
    input  logic [7:0] pac_right_data,
    input  logic [7:0] pac_closed_data,
    input  logic [7:0] pac_up_data,
    input  logic [7:0] ghost_data,
    output logic       pac_on,
    output logic       ghost_on
);

    // Sprite span in screen pixels, widened to 11 bits so x+span never wraps past 1023.
    localparam logic [10:0] SPAN = 11'(8 << SCALE_SHIFT);

    // Animation counter width; a single-frame phase still needs one bit of storage.
    localparam int                CW        = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;
    localparam logic [CW-1:0]     ANIM_LAST = CW'(ANIM_FRAMES - 1);

    localparam logic [1:0] DIR_RIGHT = 2'd0;
    localparam logic [1:0] DIR_LEFT  = 2'd1;
    localparam logic [1:0] DIR_UP    = 2'd2;

    // Which ROM / mirroring the second stage applies to the fetched row.
    localparam logic [1:0] SEL_CLOSED = 2'd0;
    localparam logic [1:0] SEL_RIGHT  = 2'd1;
    localparam logic [1:0] SEL_LEFT   = 2'd2;
    localparam logic [1:0] SEL_UP     = 2'd3;

    logic [1:0]    lat_dir;
    logic          lat_moving;
    logic [CW-1:0] anim_cnt;
    logic          mouth_closed;

    logic          pac_hit;
    logic          ghost_hit;
    logic [2:0]    pac_col;
    logic [2:0]    pac_row;
    logic [2:0]    ghost_col;
    logic [2:0]    ghost_row;
    logic          closed_now;
    logic [1:0]    pac_sel;
    logic [2:0]    pac_row_addr;

    logic          pac_hit1;
    logic          ghost_hit1;
    logic [2:0]    pac_col1;
    logic [2:0]    ghost_col1;
    logic [1:0]    pac_sel1;
    logic          pac_bit;

    // Per-frame state: direction/moving are frozen at vblank, mouth phase advances once per frame.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            lat_dir      <= DIR_RIGHT;
            lat_moving   <= 1'b0;
            anim_cnt     <= '0;
            mouth_closed <= 1'b0;
        end else if (frame_start) begin
            lat_dir    <= pac_dir;
            lat_moving <= pac_moving;
            if (!pac_moving) begin
                anim_cnt     <= '0;
                mouth_closed <= 1'b0;
            end else if (anim_cnt == ANIM_LAST) begin
                anim_cnt     <= '0;
                mouth_closed <= ~mouth_closed;
            end else begin
                anim_cnt <= anim_cnt + 1'b1;
            end
        end
    end

    // Bounding-box hit tests in 11 bits so sprites near 1023 clip instead of wrapping to 0.
    assign pac_hit   = ({1'b0, DrawX} >= {1'b0, pac_x})   && ({1'b0, DrawX} < ({1'b0, pac_x} + SPAN)) &&
                       ({1'b0, DrawY} >= {1'b0, pac_y})   && ({1'b0, DrawY} < ({1'b0, pac_y} + SPAN));
    assign ghost_hit = ({1'b0, DrawX} >= {1'b0, ghost_x}) && ({1'b0, DrawX} < ({1'b0, ghost_x} + SPAN)) &&
                       ({1'b0, DrawY} >= {1'b0, ghost_y}) && ({1'b0, DrawY} < ({1'b0, ghost_y} + SPAN));

    // Texel coordinates; only meaningful when the matching hit flag is set.
    assign pac_col   = 3'((DrawX - pac_x)   >> SCALE_SHIFT);
    assign pac_row   = 3'((DrawY - pac_y)   >> SCALE_SHIFT);
    assign ghost_col = 3'((DrawX - ghost_x) >> SCALE_SHIFT);
    assign ghost_row = 3'((DrawY - ghost_y) >> SCALE_SHIFT);

    // mouth_closed is already cleared when not moving; the gate keeps the intent explicit.
    assign closed_now = mouth_closed & lat_moving;

    // Choose the ROM and mirroring; vertical mirror is done on the address, horizontal on the bit.
    always_comb begin
        pac_sel      = SEL_CLOSED;
        pac_row_addr = pac_row;
        if (!closed_now) begin
            case (lat_dir)
                DIR_RIGHT: pac_sel = SEL_RIGHT;
                DIR_LEFT:  pac_sel = SEL_LEFT;
                DIR_UP:    pac_sel = SEL_UP;
                default: begin
                    pac_sel      = SEL_UP;
                    pac_row_addr = 3'd7 - pac_row;
                end
            endcase
        end
    end

    // Stage 1: register ROM addresses plus everything stage 2 needs to pick the bit.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            pac_addr   <= 3'd0;
            ghost_addr <= 3'd0;
            pac_hit1   <= 1'b0;
            ghost_hit1 <= 1'b0;
            pac_col1   <= 3'd0;
            ghost_col1 <= 3'd0;
            pac_sel1   <= SEL_CLOSED;
        end else begin
            pac_addr   <= pac_row_addr;
            ghost_addr <= ghost_row;
            pac_hit1   <= pac_hit;
            ghost_hit1 <= ghost_hit;
            pac_col1   <= pac_col;
            ghost_col1 <= ghost_col;
            pac_sel1   <= pac_sel;
        end
    end

    // Pick the Pac-Man texel from the row the ROMs return for the stage-1 address; bit 7 is leftmost.
    always_comb begin
        pac_bit = 1'b0;
        case (pac_sel1)
            SEL_CLOSED: pac_bit = pac_closed_data[3'd7 - pac_col1];
            SEL_RIGHT:  pac_bit = pac_right_data[3'd7 - pac_col1];
            SEL_LEFT:   pac_bit = pac_right_data[pac_col1];
            default:    pac_bit = pac_up_data[3'd7 - pac_col1];
        endcase
    end

    // Stage 2: registered flags; both may be set together, priority is the colour mapper's job.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            pac_on   <= 1'b0;
            ghost_on <= 1'b0;
        end else begin
            pac_on   <= pac_hit1 & pac_bit;
            ghost_on <= ghost_hit1 & ghost_data[3'd7 - ghost_col1];
        end
    end

endmodule

// File: tb/tb_sprite_pixel_renderer.sv
// Purpose: checks sprite_pixel_renderer flags and ROM addresses against a texel-level reference model.
// Latency: expectations are queued per driven pixel and compared 2 cycles later (addresses 1 cycle later).
// Backpressure: none; one pixel is driven every cycle.
module tb_sprite_pixel_renderer;

    localparam int SS = 1;
    localparam int AF = 2;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic       frame_start;
    logic [9:0] DrawX, DrawY;
    logic [9:0] pac_x, pac_y, ghost_x, ghost_y;
    logic [1:0] pac_dir;
    logic       pac_moving;
    logic [2:0] pac_addr, ghost_addr;
    logic [7:0] pac_right_data, pac_closed_data, pac_up_data, ghost_data;
    logic       pac_on, ghost_on;

    always #5 Clk = ~Clk;

    logic [7:0] rom_right  [8] = '{8'b00011000, 8'b00111100, 8'b01111110, 8'b01111100,
                                   8'b01111000, 8'b01111100, 8'b00111110, 8'b00011000};
    logic [7:0] rom_closed [8] = '{8'b00111100, 8'b01111110, 8'b11111111, 8'b11111111,
                                   8'b11111111, 8'b11111111, 8'b01111110, 8'b00111100};
    logic [7:0] rom_up     [8] = '{8'b00000000, 8'b01000010, 8'b01100110, 8'b11100111,
                                   8'b11111111, 8'b11111111, 8'b01111110, 8'b00111100};
    logic [7:0] rom_ghost  [8] = '{8'b00111100, 8'b01111110, 8'b11011011, 8'b11111111,
                                   8'b11111111, 8'b11111111, 8'b11111111, 8'b10100101};

    assign pac_right_data  = rom_right[pac_addr];
    assign pac_closed_data = rom_closed[pac_addr];
    assign pac_up_data     = rom_up[pac_addr];
    assign ghost_data      = rom_ghost[ghost_addr];

    sprite_pixel_renderer #(.SCALE_SHIFT(SS), .ANIM_FRAMES(AF)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_start(frame_start),
        .DrawX(DrawX), .DrawY(DrawY),
        .pac_x(pac_x), .pac_y(pac_y), .pac_dir(pac_dir), .pac_moving(pac_moving),
        .ghost_x(ghost_x), .ghost_y(ghost_y),
        .pac_addr(pac_addr), .ghost_addr(ghost_addr),
        .pac_right_data(pac_right_data), .pac_closed_data(pac_closed_data),
        .pac_up_data(pac_up_data), .ghost_data(ghost_data),
        .pac_on(pac_on), .ghost_on(ghost_on)
    );

    int n_chk = 0;
    int n_err = 0;

    // Reference state: frozen direction and the number of consecutive animated frames.
    int m_dir = 0;
    int m_run = 0;

    // Values applied to the DUT on the next drive, so input changes line up with predictions.
    int s_pac_x = 100, s_pac_y = 50, s_ghost_x = 500, s_ghost_y = 500;
    int s_dir = 0;
    bit s_moving = 1'b0;

    typedef struct {
        int x;
        int y;
        bit pac;
        bit gh;
        bit pchk;
        int paddr;
        bit gchk;
        int gaddr;
    } exp_t;

    exp_t q[$];

    task automatic chk(string tag, int got, int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int texel(logic [7:0] r, int c);
        return int'(r[7 - c]);
    endfunction

    // Sprite image as seen on screen, built from whole-image rules rather than pipeline signals.
    function automatic exp_t predict(int dx, int dy);
        exp_t e;
        int   s = 8 << SS;
        int   col, row;
        bit   closed;
        e.x = dx;
        e.y = dy;
        e.pac = 1'b0; e.gh = 1'b0; e.paddr = 0; e.gaddr = 0;
        closed = ((m_run / AF) % 2) == 1;
        e.pchk = (dx >= s_pac_x) && (dx < s_pac_x + s) && (dy >= s_pac_y) && (dy < s_pac_y + s);
        e.gchk = (dx >= s_ghost_x) && (dx < s_ghost_x + s) && (dy >= s_ghost_y) && (dy < s_ghost_y + s);
        if (e.pchk) begin
            col = (dx - s_pac_x) / (1 << SS);
            row = (dy - s_pac_y) / (1 << SS);
            e.paddr = row;
            if (closed) e.pac = texel(rom_closed[row], col) != 0;
            else begin
                case (m_dir)
                    0: e.pac = texel(rom_right[row], col) != 0;
                    1: e.pac = texel(rom_right[row], 7 - col) != 0;
                    2: e.pac = texel(rom_up[row], col) != 0;
                    default: begin
                        e.pac   = texel(rom_up[7 - row], col) != 0;
                        e.paddr = 7 - row;
                    end
                endcase
            end
        end
        if (e.gchk) begin
            col = (dx - s_ghost_x) / (1 << SS);
            row = (dy - s_ghost_y) / (1 << SS);
            e.gaddr = row;
            e.gh = texel(rom_ghost[row], col) != 0;
        end
        return e;
    endfunction

    // One pixel per cycle: check what is due at this negedge, then drive the next pixel.
    task automatic step(bit rst, bit fs, int dx, int dy);
        exp_t b;
        exp_t z;
        @(negedge Clk);
        if (q.size() >= 1) begin
            b = q[q.size() - 1];
            if (b.pchk) chk($sformatf("pac_addr x=%0d y=%0d", b.x, b.y), int'(pac_addr), b.paddr);
            if (b.gchk) chk($sformatf("ghost_addr x=%0d y=%0d", b.x, b.y), int'(ghost_addr), b.gaddr);
        end
        if (q.size() == 2) begin
            b = q.pop_front();
            chk($sformatf("pac_on x=%0d y=%0d", b.x, b.y), int'(pac_on), int'(b.pac));
            chk($sformatf("ghost_on x=%0d y=%0d", b.x, b.y), int'(ghost_on), int'(b.gh));
        end
        pac_x       = 10'(s_pac_x);
        pac_y       = 10'(s_pac_y);
        ghost_x     = 10'(s_ghost_x);
        ghost_y     = 10'(s_ghost_y);
        pac_dir     = 2'(s_dir);
        pac_moving  = s_moving;
        Reset_n     = rst;
        frame_start = fs & rst;
        DrawX       = 10'(dx);
        DrawY       = 10'(dy);
        if (!rst) begin
            z.x = dx; z.y = dy; z.pac = 1'b0; z.gh = 1'b0;
            z.pchk = 1'b1; z.paddr = 0; z.gchk = 1'b1; z.gaddr = 0;
            foreach (q[i]) q[i] = z;
            q.push_back(z);
            m_dir = 0;
            m_run = 0;
        end else begin
            q.push_back(predict(dx, dy));
            if (fs) begin
                m_dir = s_dir;
                if (s_moving) m_run++;
                else m_run = 0;
            end
        end
    endtask

    task automatic sweep(int y, int x0, int x1);
        for (int x = x0; x <= x1; x++) step(1'b1, 1'b0, x, y);
    endtask

    task automatic pulse();
        step(1'b1, 1'b1, 0, 0);
    endtask

    initial begin
        int r, bx, by, dx, dy;
        bit fs, rst;
        Reset_n = 1'b0; frame_start = 1'b0; DrawX = '0; DrawY = '0;
        pac_x = 10'd100; pac_y = 10'd50; ghost_x = 10'd500; ghost_y = 10'd500;
        pac_dir = 2'd0; pac_moving = 1'b0;

        repeat (3) step(1'b0, 1'b0, 0, 0);

        // Right-facing open mouth, row 0 sweep including both horizontal boundaries.
        pulse();
        sweep(50, 96, 120);

        // Reset held for five cycles in the middle of a scan line.
        sweep(50, 100, 104);
        repeat (5) step(1'b0, 1'b0, 106, 50);
        sweep(50, 105, 120);

        // Left mirror on row 3, then a mid-frame direction change that must not take effect.
        s_dir = 1; pulse();
        sweep(56, 96, 120);
        s_dir = 2;
        sweep(56, 96, 120);

        // Down: vertical mirror through the address.
        s_dir = 3; pulse();
        sweep(64, 96, 120);
        sweep(50, 96, 120);

        // Mouth animation over eight frames, then stop moving.
        s_dir = 0; s_moving = 1'b1;
        for (int f = 0; f < 8; f++) begin
            pulse();
            for (int y = 50; y < 66; y += 2) sweep(y, 100, 115);
        end
        s_moving = 1'b0; pulse();
        for (int y = 50; y < 66; y += 2) sweep(y, 100, 115);

        // Right-edge clipping with both sprites overlapping.
        s_pac_x = 1020; s_ghost_x = 1020; s_ghost_y = 50; pulse();
        for (int y = 48; y < 66; y += 3) begin
            sweep(y, 1012, 1023);
            sweep(y, 0, 11);
        end

        // Randomized scan near the sprites with occasional moves, frames and resets.
        for (int i = 0; i < 5000; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 2) begin
                s_pac_x = int'($urandom_range(0, 1023));
                s_pac_y = int'($urandom_range(0, 1023));
                s_ghost_x = ($urandom_range(0, 2) == 0) ? s_pac_x : int'($urandom_range(0, 1023));
                s_ghost_y = ($urandom_range(0, 2) == 0) ? s_pac_y : int'($urandom_range(0, 1023));
            end else if (r < 8) begin
                s_dir = int'($urandom_range(0, 3));
                s_moving = ($urandom_range(0, 3) != 0);
            end
            fs  = ($urandom_range(0, 30) == 0);
            rst = ($urandom_range(0, 499) != 0);
            bx  = ($urandom_range(0, 1) == 1) ? s_pac_x : s_ghost_x;
            by  = ($urandom_range(0, 1) == 1) ? s_pac_y : s_ghost_y;
            dx  = (bx + int'($urandom_range(0, 19)) - 2) & 1023;
            dy  = (by + int'($urandom_range(0, 19)) - 2) & 1023;
            step(rst, fs, dx, dy);
        end

        repeat (3) step(1'b1, 1'b0, 0, 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
